// File: rtl/usb_handshake_responder.sv
// Low-speed USB device handshake sequencer: decides ACK/NAK/STALL/silence for OUT/SETUP
// transactions, tracks per-endpoint data toggles and emits the 1-byte handshake packet.
module usb_handshake_responder #(
    parameter int unsigned NUM_EP     = 16,
    parameter int unsigned TURNAROUND = 32,
    parameter int unsigned TIMEOUT    = 288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        dev_address,
    input  logic              token_valid,
    input  logic [3:0]        pid,
    input  logic [6:0]        address,
    input  logic [3:0]        end_point,
    input  logic              packet_end,
    input  logic              packet_ok,
    input  logic              rx_active,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [NUM_EP-1:0] ep_ready,
    input  logic [NUM_EP-1:0] ep_toggle_clr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              data_accept,
    output logic              setup_rcvd,
    output logic              in_req,
    output logic [3:0]        cur_ep,
    output logic              timeout,
    output logic              busy
);

    localparam int unsigned CNT_MAX = (TIMEOUT > TURNAROUND) ? TIMEOUT : TURNAROUND;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_TURN,
        ST_SEND
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              is_setup;
    logic [3:0]        hs_q;
    logic [NUM_EP-1:0] toggle;

    logic              own_token_c;
    logic              restart_c;
    logic              is_data_c;
    logic              good_data_c;
    logic [3:0]        hs_c;
    logic              accept_c;
    logic [NUM_EP-1:0] tog_set_c;
    logic [NUM_EP-1:0] tog_flip_c;

    assign busy = (state != ST_IDLE);

    // Handshake decision for the payload that ends this cycle
    always_comb begin
        own_token_c = token_valid && (address == dev_address) && (32'(end_point) < NUM_EP);
        restart_c   = own_token_c && ((pid == PID_OUT) || (pid == PID_SETUP));
        is_data_c   = (pid == PID_DATA0) || (pid == PID_DATA1);
        good_data_c = (state == ST_WAIT_DATA) && !restart_c && packet_end && packet_ok && is_data_c;
        hs_c        = PID_ACK;
        accept_c    = 1'b0;
        tog_set_c   = '0;
        tog_flip_c  = '0;
        if (is_setup) begin
            accept_c          = 1'b1;
            tog_set_c[cur_ep] = 1'b1;
        end else if (ep_stall[cur_ep]) begin
            hs_c = PID_STALL;
        end else if (!ep_ready[cur_ep]) begin
            hs_c = PID_NAK;
        end else if (pid[3] == toggle[cur_ep]) begin
            accept_c           = 1'b1;
            tog_flip_c[cur_ep] = 1'b1;
        end
        if (!good_data_c) begin
            accept_c   = 1'b0;
            tog_set_c  = '0;
            tog_flip_c = '0;
        end
    end

    // Toggle bits; a level clear overrides any same-cycle set or flip
    always_ff @(posedge clk) begin
        if (!reset) begin
            toggle <= '0;
        end else begin
            toggle <= ((toggle ^ tog_flip_c) | tog_set_c) & ~ep_toggle_clr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            is_setup    <= 1'b0;
            hs_q        <= '0;
            cur_ep      <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            data_accept <= 1'b0;
            setup_rcvd  <= 1'b0;
            in_req      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            data_accept <= 1'b0;
            setup_rcvd  <= 1'b0;
            in_req      <= 1'b0;
            timeout     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (restart_c) begin
                        cur_ep   <= end_point;
                        is_setup <= (pid == PID_SETUP);
                        cnt      <= '0;
                        state    <= ST_WAIT_DATA;
                    end else if (own_token_c && (pid == PID_IN)) begin
                        in_req <= 1'b1;
                        cur_ep <= end_point;
                    end
                end
                ST_WAIT_DATA: begin
                    if (restart_c) begin
                        cur_ep   <= end_point;
                        is_setup <= (pid == PID_SETUP);
                        cnt      <= '0;
                    end else if (packet_end) begin
                        if (good_data_c) begin
                            hs_q        <= hs_c;
                            data_accept <= accept_c;
                            setup_rcvd  <= accept_c && is_setup;
                            cnt         <= '0;
                            state       <= ST_TURN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (!rx_active) begin
                        if (cnt == CNT_W'(TIMEOUT - 1)) begin
                            timeout <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_TURN: begin
                    // Host still talking: the bus is not ours, drop the handshake
                    if (rx_active) begin
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(TURNAROUND - 1)) begin
                        tx_data  <= {~hs_q, hs_q};
                        tx_valid <= 1'b1;
                        state    <= ST_SEND;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_handshake_responder.sv
// Bench for usb_handshake_responder: directed scenarios plus random transactions,
// checked every cycle against a transaction-level model using absolute edge deadlines.
module tb_usb_handshake_responder;

    localparam int TURNAROUND = 32;
    localparam int TIMEOUT    = 288;
    localparam logic [6:0] DEV = 7'h15;

    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_SETUP = 4'b1101;
    localparam logic [3:0] P_DATA0 = 4'b0011;
    localparam logic [3:0] P_DATA1 = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  dev_address = DEV;
    logic        token_valid = 1'b0;
    logic [3:0]  pid = 4'b0;
    logic [6:0]  address = 7'h0;
    logic [3:0]  end_point = 4'h0;
    logic        packet_end = 1'b0;
    logic        packet_ok = 1'b0;
    logic        rx_active = 1'b0;
    logic [15:0] ep_stall = 16'h0;
    logic [15:0] ep_ready = 16'hFFFF;
    logic [15:0] ep_toggle_clr = 16'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        data_accept;
    logic        setup_rcvd;
    logic        in_req;
    logic [3:0]  cur_ep;
    logic        timeout;
    logic        busy;

    usb_handshake_responder #(
        .NUM_EP(16), .TURNAROUND(TURNAROUND), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .dev_address(dev_address),
        .token_valid(token_valid), .pid(pid), .address(address), .end_point(end_point),
        .packet_end(packet_end), .packet_ok(packet_ok), .rx_active(rx_active),
        .ep_stall(ep_stall), .ep_ready(ep_ready), .ep_toggle_clr(ep_toggle_clr),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .data_accept(data_accept), .setup_rcvd(setup_rcvd), .in_req(in_req),
        .cur_ep(cur_ep), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction either waits for data, holds a handshake due at an
    // absolute edge number, or is on the wire until the serializer takes it.
    int          edge_n = 0;
    bit          w_act = 1'b0;
    int          w_quiet = 0;
    bit          h_pend = 1'b0;
    int          h_due = 0;
    bit          h_send = 1'b0;
    logic [7:0]  h_byte = 8'h0;
    logic [15:0] m_tog = 16'h0;
    logic [3:0]  m_ep = 4'h0;
    bit          m_setup = 1'b0;
    logic        e_txv = 1'b0;
    logic [7:0]  e_txd = 8'h0;
    logic        e_da = 1'b0, e_sr = 1'b0, e_in = 1'b0, e_to = 1'b0;

    always @(posedge clk) begin
        bit own, tok_os;
        e_da = 1'b0; e_sr = 1'b0; e_in = 1'b0; e_to = 1'b0;
        if (!reset) begin
            w_act = 1'b0; h_pend = 1'b0; h_send = 1'b0; m_setup = 1'b0;
            m_tog = 16'h0; m_ep = 4'h0; e_txv = 1'b0; e_txd = 8'h0;
        end else begin
            own    = token_valid && (address == DEV);
            tok_os = own && (pid == P_OUT || pid == P_SETUP);
            if (h_send) begin
                if (tx_ready) begin h_send = 1'b0; e_txv = 1'b0; e_txd = 8'h0; end
            end else if (h_pend) begin
                if (rx_active) h_pend = 1'b0;
                else if (edge_n == h_due) begin
                    h_pend = 1'b0; h_send = 1'b1; e_txv = 1'b1; e_txd = h_byte;
                end
            end else if (w_act) begin
                if (tok_os) begin
                    m_ep = end_point; m_setup = (pid == P_SETUP); w_quiet = 0;
                end else if (packet_end) begin
                    w_act = 1'b0;
                    if (packet_ok && (pid == P_DATA0 || pid == P_DATA1)) begin
                        if (m_setup) begin
                            h_byte = 8'hD2; e_da = 1'b1; e_sr = 1'b1; m_tog[m_ep] = 1'b1;
                        end else if (ep_stall[m_ep]) begin
                            h_byte = 8'h1E;
                        end else if (!ep_ready[m_ep]) begin
                            h_byte = 8'h5A;
                        end else begin
                            h_byte = 8'hD2;
                            if ((pid == P_DATA1) == m_tog[m_ep]) begin
                                e_da = 1'b1; m_tog[m_ep] = ~m_tog[m_ep];
                            end
                        end
                        h_pend = 1'b1;
                        h_due  = edge_n + TURNAROUND;
                    end
                end else if (!rx_active) begin
                    w_quiet++;
                    if (w_quiet == TIMEOUT) begin w_act = 1'b0; e_to = 1'b1; end
                end
            end else if (tok_os) begin
                w_act = 1'b1; w_quiet = 0; m_ep = end_point; m_setup = (pid == P_SETUP);
            end else if (own && pid == P_IN) begin
                e_in = 1'b1; m_ep = end_point;
            end
            m_tog = m_tog & ~ep_toggle_clr;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_tx_valid", 32'(tx_valid), 32'(e_txv));
            chk("cyc_tx_data", 32'(tx_data), 32'(e_txd));
            chk("cyc_data_accept", 32'(data_accept), 32'(e_da));
            chk("cyc_setup_rcvd", 32'(setup_rcvd), 32'(e_sr));
            chk("cyc_in_req", 32'(in_req), 32'(e_in));
            chk("cyc_timeout", 32'(timeout), 32'(e_to));
            chk("cyc_busy", 32'(busy), 32'(w_act || h_pend || h_send));
            chk("cyc_cur_ep", 32'(cur_ep), 32'(m_ep));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send_token(input logic [3:0] p, input logic [6:0] a, input logic [3:0] ep);
        token_valid = 1'b1; pid = p; address = a; end_point = ep;
        step();
        token_valid = 1'b0;
    endtask

    task automatic send_data(input logic [3:0] p, input logic ok);
        rx_active = 1'b1;
        repeat (2) step();
        rx_active = 1'b0; pid = p; packet_ok = ok; packet_end = 1'b1;
        step();
        packet_end = 1'b0; packet_ok = 1'b0;
    endtask

    // Drain whatever the model says is outstanding, answering tx_valid after `dly` cycles
    task automatic finish_txn(input int dly);
        int n;
        for (n = 0; n < 400; n++) begin
            if (!(w_act || h_pend || h_send)) break;
            if (e_txv) begin
                repeat (dly) step();
                tx_ready = 1'b1;
                step();
                tx_ready = 1'b0;
            end else begin
                step();
            end
        end
        if (n == 400) begin
            checks++; errors++;
            $display("FAIL finish_txn actual=busy required=idle @%0t", $time);
        end
    endtask

    task automatic xact(input logic [3:0] tp, input logic [3:0] ep, input logic [3:0] dp,
                        input logic [7:0] exp_hs, input logic exp_acc, input string tag);
        send_token(tp, DEV, ep);
        step();
        send_data(dp, 1'b1);
        chk({tag, "_accept"}, 32'(data_accept), 32'(exp_acc));
        repeat (TURNAROUND - 1) step();
        chk({tag, "_early"}, 32'(tx_valid), 0);
        step();
        chk({tag, "_valid"}, 32'(tx_valid), 1);
        chk({tag, "_byte"}, 32'(tx_data), 32'(exp_hs));
        chk({tag, "_model"}, 32'(e_txd), 32'(exp_hs));
        repeat (2) step();
        chk({tag, "_hold"}, 32'(tx_data), 32'(exp_hs));
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk({tag, "_done"}, 32'(tx_valid), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running required=finished @%0t", $time);
        $fatal(1);
    end

    initial begin
        logic [3:0] tp, dp;
        logic [6:0] ta;
        repeat (3) step();
        chk_en = 1'b1;
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_ep", 32'(cur_ep), 0);
        reset = 1'b1;
        step();

        // SETUP to endpoint 14
        xact(P_SETUP, 4'hE, P_DATA0, 8'hD2, 1'b1, "t1");
        chk("t1_model_tog14", 32'(m_tog[14]), 1);
        repeat (3) step();

        // OUT toggle sequencing on endpoint 2
        xact(P_OUT, 4'h2, P_DATA0, 8'hD2, 1'b1, "t2a");
        xact(P_OUT, 4'h2, P_DATA0, 8'hD2, 1'b0, "t2b");
        xact(P_OUT, 4'h2, P_DATA1, 8'hD2, 1'b1, "t2c");

        // STALL then NAK leave the toggle alone
        ep_stall[2] = 1'b1;
        xact(P_OUT, 4'h2, P_DATA0, 8'h1E, 1'b0, "t3s");
        ep_stall[2] = 1'b0; ep_ready[2] = 1'b0;
        xact(P_OUT, 4'h2, P_DATA0, 8'h5A, 1'b0, "t3n");
        ep_ready[2] = 1'b1;
        xact(P_OUT, 4'h2, P_DATA0, 8'hD2, 1'b1, "t3a");

        // Foreign address is silent; IN to own address pulses in_req
        send_token(P_OUT, 7'h3A, 4'h2);
        chk("t4_busy", 32'(busy), 0);
        send_data(P_DATA0, 1'b1);
        repeat (40) step();
        send_token(P_IN, DEV, 4'h4);
        chk("t4_in_req", 32'(in_req), 1);
        chk("t4_cur_ep", 32'(cur_ep), 4);
        step();
        chk("t4_in_req_end", 32'(in_req), 0);

        // No DATA within the timeout window, then a corrupt DATA
        send_token(P_OUT, DEV, 4'h1);
        repeat (TIMEOUT - 1) step();
        chk("t5_no_to_yet", 32'(timeout), 0);
        step();
        chk("t5_timeout", 32'(timeout), 1);
        chk("t5_idle", 32'(busy), 0);
        send_token(P_OUT, DEV, 4'h1);
        send_data(P_DATA0, 1'b0);
        chk("t5_bad_idle", 32'(busy), 0);
        repeat (40) step();

        // Reset during SEND clears toggles and the pending handshake
        send_token(P_SETUP, DEV, 4'h3);
        send_data(P_DATA0, 1'b1);
        repeat (TURNAROUND) step();
        chk("t6_send", 32'(tx_valid), 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_rst_valid", 32'(tx_valid), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_model_tog", 32'(m_tog), 0);
        xact(P_OUT, 4'hE, P_DATA0, 8'hD2, 1'b1, "t6e");

        // Reset mid-turnaround
        send_token(P_OUT, DEV, 4'h7);
        send_data(P_DATA0, 1'b1);
        repeat (10) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_turn_busy", 32'(busy), 0);
        repeat (40) step();

        // Level clear wins over the flip of an accepted packet
        send_token(P_OUT, DEV, 4'h5);
        ep_toggle_clr[5] = 1'b1;
        send_data(P_DATA0, 1'b1);
        step();
        ep_toggle_clr[5] = 1'b0;
        finish_txn(1);
        xact(P_OUT, 4'h5, P_DATA0, 8'hD2, 1'b1, "t6c");

        // Random transactions
        for (int n = 0; n < 150; n++) begin
            ep_stall = 16'($urandom) & 16'($urandom) & 16'($urandom);
            ep_ready = 16'($urandom) | 16'($urandom);
            if ($urandom_range(0, 19) == 0) ep_toggle_clr = 16'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: tp = P_OUT;
                5, 6:          tp = P_SETUP;
                7, 8:          tp = P_IN;
                default:       tp = P_ACK;
            endcase
            ta = ($urandom_range(0, 7) == 0) ? 7'($urandom) : DEV;
            send_token(tp, ta, 4'($urandom));
            ep_toggle_clr = 16'h0;
            repeat ($urandom_range(0, 3)) step();
            if ($urandom_range(0, 29) == 0) begin
                repeat (TIMEOUT + 5) step();
            end else begin
                if ($urandom_range(0, 9) == 0) dp = P_NAK;
                else dp = $urandom_range(0, 1) ? P_DATA1 : P_DATA0;
                send_data(dp, $urandom_range(0, 9) != 0);
            end
            if ($urandom_range(0, 9) == 0) begin
                repeat ($urandom_range(0, TURNAROUND - 1)) step();
                rx_active = 1'b1;
                step();
                rx_active = 1'b0;
            end
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
            end
            finish_txn($urandom_range(0, 4));
            step();
        end

        repeat (5) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
